mc6502_interrupt_sequencer: RTL and testbench
=============================================

Name: mc6502_interrupt_sequencer

Overview:
Interrupt/reset entry sequencer for the 6502 core. It sits between the control decoder and the processor status register. It polls RESET/NMI/IRQ/BRK at instruction boundaries and runs the 7-cycle entry sequence: push PCH, PCL and P, then fetch the vector. It drives the status register's I and B update strobes and reads back the current PSR for masking and for the pushed value.

Parameters:
VEC_NMI, 16'hFFFA, NMI vector low-byte address
VEC_RST, 16'hFFFC, reset vector low-byte address
VEC_IRQ, 16'hFFFE, IRQ/BRK vector low-byte address

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
i_rdy  in  1  core advance enable; 0 freezes sequencer state
i_fetch  in  1  instruction boundary (opcode fetch cycle)
i_brk  in  1  BRK decoded; qualified by i_fetch
i_nmi  in  1  NMI request, active-high, already synchronised; rising edge triggers
i_irq  in  1  IRQ request, active-high level
i_psr  in  8  current PSR (bit2 = I)
o_busy  out  1  sequence in progress (S1..S7)
o_push_pch  out  1  write PC[15:8] to stack this cycle
o_push_pcl  out  1  write PC[7:0] to stack this cycle
o_push_p  out  1  write o_p_value to stack this cycle
o_sp_dec  out  1  decrement SP this cycle
o_p_value  out  8  {i_psr[7:6],1,b_src,i_psr[3:0]}
o_vec_lo  out  1  read vector low byte this cycle
o_vec_hi  out  1  read vector high byte this cycle
o_vector_addr  out  16  vector byte address
o_set_i, o_i  out  1,1  PSR I update strobe/value
o_set_b, o_b  out  1,1  PSR B update strobe/value
o_done  out  1  final cycle pulse; next cycle is opcode fetch at new PC

Behaviour:
- Reset: all outputs 0, state IDLE, nmi_pending=0, rst_pending=1, nmi_prev=0.
- rst asserted mid-sequence: same values next cycle; in-flight sequence abandoned.
- NMI edge detect: nmi_pending set when i_nmi=1 and nmi_prev=0. nmi_prev updates every cycle, including when i_rdy=0.
- Start (IDLE, i_rdy=1):
  - rst_pending → enter S1 regardless of i_fetch.
  - Else, when i_fetch=1, enter S1 on any of: nmi_pending, (i_irq & ~i_psr[2]), or i_brk.
  - Latch source at start, priority RST > NMI > IRQ > BRK. b_src=1 only for BRK.
- States S1..S7; one state per cycle when i_rdy=1; hold with strobes still asserted when i_rdy=0.
  - S1, S2: dummy cycles; o_busy only.
  - S3: o_push_pch, o_sp_dec.
  - S4: o_push_pcl, o_sp_dec.
  - S5: o_push_p, o_sp_dec; o_set_i=1, o_i=1; o_set_b=1, o_b=b_src. The PSR changes after the push, so the pushed I is the pre-entry value.
  - Vector selection is frozen in S5: RST if source is RST; else NMI if nmi_pending (hijack of IRQ/BRK); else IRQ. nmi_pending clears in S5 when NMI is chosen.
  - S6: o_vec_lo, o_vector_addr = vec.
  - S7: o_vec_hi, o_vector_addr = vec+1, o_done → IDLE. rst_pending clears in S7 of a RST sequence.
- RST sequence: o_push_* forced 0; o_sp_dec still pulses in S3–S5; o_set_b=0; I is set.
- NMI edge arriving after S5: remains pending, taken at the next i_fetch.
- IRQ deasserted after start: sequence completes with IRQ vector.
- Simultaneous NMI edge and IRQ at a boundary: NMI taken; IRQ is re-evaluated at the next boundary, where I=1 masks it.
- i_fetch ignored while o_busy.
- Sequence length is exactly 7 cycles with i_rdy=1.

Decomposition:
- Shared package holds: state encoding (IDLE, S1..S7), source encoding (SRC_RST, SRC_NMI, SRC_IRQ, SRC_BRK), vector constants, PSR bit indices (N=7, V=6, B=4, D=3, I=2, Z=1, C=0).
- One sub-module, mc6502_nmi_edge_detector: edge register plus pending flag, with set and clear inputs.

Test Plan:
- Release rst, i_rdy=1 → busy 7 cycles; no o_push_*; o_sp_dec in S3–S5; o_vector_addr FFFC then FFFD; o_set_i/o_i=1 in S5; o_done in S7.
- i_psr=8'h20, i_irq=1, i_fetch=1 → S3 push_pch, S4 push_pcl, S5 push_p with o_p_value=8'h20, o_set_i=1; vectors FFFE/FFFF.
- i_psr=8'h24 (I set), i_irq=1, i_fetch=1 → no entry, o_busy stays 0; i_nmi 0→1 then i_fetch → vectors FFFA/FFFB.
- i_brk=1 at i_fetch, i_psr=8'h24 → o_p_value=8'h34, o_b=1; then NMI edge in S2 → vector FFFA (hijack), nmi_pending cleared.
- IRQ sequence with i_rdy=0 held 3 cycles in S4 → o_push_pcl held 3 cycles; total 10 cycles.
- rst pulsed in S4 of an IRQ sequence → outputs 0 next cycle, then a full RST sequence (FFFC).

Source files
------------

// File: rtl/mc6502_interrupt_sequencer_pkg.sv
// Shared definitions for the 6502 interrupt/reset entry sequencer.
//   state_t : sequencer state (IDLE, S1..S7)
//   src_t   : interrupt source latched at sequence start
//   VEC_*   : default vector low-byte addresses
//   PSR_*   : processor status register bit indices
package mc6502_interrupt_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        S4,
        S5,
        S6,
        S7
    } state_t;

    typedef enum logic [1:0] {
        SRC_RST,
        SRC_NMI,
        SRC_IRQ,
        SRC_BRK
    } src_t;

    localparam logic [15:0] VEC_NMI_DEFAULT = 16'hFFFA;
    localparam logic [15:0] VEC_RST_DEFAULT = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ_DEFAULT = 16'hFFFE;

    localparam int unsigned PSR_N = 7;
    localparam int unsigned PSR_V = 6;
    localparam int unsigned PSR_B = 4;
    localparam int unsigned PSR_D = 3;
    localparam int unsigned PSR_I = 2;
    localparam int unsigned PSR_Z = 1;
    localparam int unsigned PSR_C = 0;

endpackage

// File: rtl/mc6502_nmi_edge_detector.sv
// NMI rising-edge detector with pending flag.
//   clk, rst  : clock, synchronous active-high reset
//   i_nmi     : synchronised NMI request level
//   i_clr     : clear the pending flag (NMI vector chosen)
//   o_pending : an NMI edge has been seen and not yet serviced
// The edge register updates every cycle regardless of core stalls.
module mc6502_nmi_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic i_nmi,
    input  logic i_clr,
    output logic o_pending
);

    logic nmi_prev;
    logic pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_prev <= 1'b0;
            pending  <= 1'b0;
        end else begin
            nmi_prev <= i_nmi;
            // A fresh edge wins over a clear so it is never lost.
            if (i_nmi && !nmi_prev)
                pending <= 1'b1;
            else if (i_clr)
                pending <= 1'b0;
        end
    end

    assign o_pending = pending;

endmodule

// File: rtl/mc6502_interrupt_sequencer.sv
// 6502 interrupt/reset entry sequencer. Polls RESET/NMI/IRQ/BRK at
// instruction boundaries and runs the 7-cycle entry: two dummy cycles,
// push PCH, PCL, P, then read vector low and high bytes.
//   clk, rst        : clock, synchronous active-high reset
//   i_rdy           : core advance enable (0 freezes the sequence)
//   i_fetch, i_brk  : opcode fetch boundary, BRK decoded
//   i_nmi, i_irq    : NMI (edge) and IRQ (level) requests
//   i_psr           : current status register
//   o_busy          : sequence in progress
//   o_push_*, o_sp_dec, o_p_value : stack write strobes and P byte
//   o_vec_lo/hi, o_vector_addr    : vector fetch strobes and address
//   o_set_i/o_i, o_set_b/o_b      : status register update strobes
//   o_done          : last cycle of the sequence
module mc6502_interrupt_sequencer
    import mc6502_interrupt_sequencer_pkg::*;
#(
    parameter logic [15:0] VEC_NMI = VEC_NMI_DEFAULT,
    parameter logic [15:0] VEC_RST = VEC_RST_DEFAULT,
    parameter logic [15:0] VEC_IRQ = VEC_IRQ_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_rdy,
    input  logic        i_fetch,
    input  logic        i_brk,
    input  logic        i_nmi,
    input  logic        i_irq,
    input  logic [7:0]  i_psr,
    output logic        o_busy,
    output logic        o_push_pch,
    output logic        o_push_pcl,
    output logic        o_push_p,
    output logic        o_sp_dec,
    output logic [7:0]  o_p_value,
    output logic        o_vec_lo,
    output logic        o_vec_hi,
    output logic [15:0] o_vector_addr,
    output logic        o_set_i,
    output logic        o_i,
    output logic        o_set_b,
    output logic        o_b
    ,
    output logic        o_done
);

    state_t      state, state_nxt;
    src_t        src, src_nxt;
    src_t        vec_sel, vec_sel_nxt;
    logic        rst_pending;
    logic        nmi_pending;
    logic        nmi_clr;
    logic        is_rst;
    logic        b_src;
    logic [15:0] vec;
    logic [7:0]  p_byte;

    assign is_rst = (src == SRC_RST);
    assign b_src  = (src == SRC_BRK);

    // NMI hijacks IRQ/BRK if pending when S5 advances.
    assign nmi_clr = (state == S5) && i_rdy && !is_rst && nmi_pending;

    mc6502_nmi_edge_detector u_nmi (
        .clk       (clk),
        .rst       (rst),
        .i_nmi     (i_nmi),
        .i_clr     (nmi_clr),
        .o_pending (nmi_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            src         <= SRC_RST;
            vec_sel     <= SRC_RST;
            rst_pending <= 1'b1;
        end else begin
            state   <= state_nxt;
            src     <= src_nxt;
            vec_sel <= vec_sel_nxt;
            if (i_rdy && (state == S7) && is_rst)
                rst_pending <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        src_nxt     = src;
        vec_sel_nxt = vec_sel;
        if (i_rdy) begin
            case (state)
                IDLE: begin
                    if (rst_pending) begin
                        state_nxt = S1;
                        src_nxt   = SRC_RST;
                    end else if (i_fetch) begin
                        if (nmi_pending) begin
                            state_nxt = S1;
                            src_nxt   = SRC_NMI;
                        end else if (i_irq && !i_psr[PSR_I]) begin
                            state_nxt = S1;
                            src_nxt   = SRC_IRQ;
                        end else if (i_brk) begin
                            state_nxt = S1;
                            src_nxt   = SRC_BRK;
                        end
                    end
                end
                S1: state_nxt = S2;
                S2: state_nxt = S3;
                S3: state_nxt = S4;
                S4: state_nxt = S5;
                S5: begin
                    state_nxt = S6;
                    if (is_rst)
                        vec_sel_nxt = SRC_RST;
                    else if (nmi_pending)
                        vec_sel_nxt = SRC_NMI;
                    else
                        vec_sel_nxt = SRC_IRQ;
                end
                S6: state_nxt = S7;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        case (vec_sel)
            SRC_RST: vec = VEC_RST;
            SRC_NMI: vec = VEC_NMI;
            default: vec = VEC_IRQ;
        endcase
    end

    // Pushed P: bit 5 always 1, B reflects the source.
    always_comb begin
        p_byte        = i_psr;
        p_byte[5]     = 1'b1;
        p_byte[PSR_B] = b_src;
    end

    always_comb begin
        o_busy        = (state != IDLE);
        o_push_pch    = 1'b0;
        o_push_pcl    = 1'b0;
        o_push_p      = 1'b0;
        o_sp_dec      = 1'b0;
        o_p_value     = '0;
        o_vec_lo      = 1'b0;
        o_vec_hi      = 1'b0;
        o_vector_addr = '0;
        o_set_i       = 1'b0;
        o_i           = 1'b0;
        o_set_b       = 1'b0;
        o_b           = 1'b0;
        o_done        = 1'b0;
        case (state)
            S3: begin
                o_push_pch = !is_rst;
                o_sp_dec   = 1'b1;
            end
            S4: begin
                o_push_pcl = !is_rst;
                o_sp_dec   = 1'b1;
            end
            S5: begin
                o_push_p  = !is_rst;
                o_sp_dec  = 1'b1;
                o_p_value = p_byte;
                o_set_i   = 1'b1;
                o_i       = 1'b1;
                o_set_b   = !is_rst;
                o_b       = b_src;
            end
            S6: begin
                o_vec_lo      = 1'b1;
                o_vector_addr = vec;
            end
            S7: begin
                o_vec_hi      = 1'b1;
                o_vector_addr = vec + 16'd1;
                o_done        = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// Directed self-checking bench for mc6502_interrupt_sequencer.
module tb_mc6502_interrupt_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rdy;
    logic        i_fetch;
    logic        i_brk;
    logic        i_nmi;
    logic        i_irq;
    logic [7:0]  i_psr;
    logic        o_busy;
    logic        o_push_pch;
    logic        o_push_pcl;
    logic        o_push_p;
    logic        o_sp_dec;
    logic [7:0]  o_p_value;
    logic        o_vec_lo;
    logic        o_vec_hi;
    logic [15:0] o_vector_addr;
    logic        o_set_i;
    logic        o_i;
    logic        o_set_b;
    logic        o_b;
    logic        o_done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mc6502_interrupt_sequencer #(
        .VEC_NMI(16'hFFFA),
        .VEC_RST(16'hFFFC),
        .VEC_IRQ(16'hFFFE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_rdy         (i_rdy),
        .i_fetch       (i_fetch),
        .i_brk         (i_brk),
        .i_nmi         (i_nmi),
        .i_irq         (i_irq),
        .i_psr         (i_psr),
        .o_busy        (o_busy),
        .o_push_pch    (o_push_pch),
        .o_push_pcl    (o_push_pcl),
        .o_push_p      (o_push_p),
        .o_sp_dec      (o_sp_dec),
        .o_p_value     (o_p_value),
        .o_vec_lo      (o_vec_lo),
        .o_vec_hi      (o_vec_hi),
        .o_vector_addr (o_vector_addr),
        .o_set_i       (o_set_i),
        .o_i           (o_i),
        .o_set_b       (o_set_b),
        .o_b           (o_b),
        .o_done        (o_done)
    );

    // Output bundle order:
    // busy,pch,pcl,p,sp_dec,vec_lo,vec_hi,set_i,i,set_b,b,done,p_value[8],addr[16]
    function automatic logic [35:0] observed();
        return {o_busy, o_push_pch, o_push_pcl, o_push_p, o_sp_dec, o_vec_lo,
                o_vec_hi, o_set_i, o_i, o_set_b, o_b, o_done, o_p_value, o_vector_addr};
    endfunction

    // Expected outputs in sequence cycle n (0 = idle).
    function automatic logic [35:0] expected(int n, bit rs, bit bs,
                                             logic [7:0] pv, logic [15:0] vec);
        logic [11:0] f;
        logic [7:0]  p;
        logic [15:0] a;
        f = '0;
        p = '0;
        a = '0;
        f[11] = (n >= 1);
        f[10] = (n == 3) && !rs;
        f[9]  = (n == 4) && !rs;
        f[8]  = (n == 5) && !rs;
        f[7]  = (n >= 3) && (n <= 5);
        f[6]  = (n == 6);
        f[5]  = (n == 7);
        f[4]  = (n == 5);
        f[3]  = (n == 5);
        f[2]  = (n == 5) && !rs;
        f[1]  = (n == 5) && bs;
        f[0]  = (n == 7);
        if (n == 5) p = pv;
        if (n == 6) a = vec;
        if (n == 7) a = vec + 16'd1;
        return {f, p, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [35:0] exp);
        logic [35:0] obs;
        obs = observed();
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walk S1..S7 (already in S1), then check idle. Optionally raise NMI
    // during cycle nmi_at, and stall 3 cycles in cycle stall_at.
    task automatic run_seq(input string tag, input bit rs, input bit bs,
                           input logic [7:0] pv, input logic [15:0] vec,
                           input int nmi_at, input int stall_at);
        for (int n = 1; n <= 7; n++) begin
            check($sformatf("%s_s%0d", tag, n), expected(n, rs, bs, pv, vec));
            if (n == nmi_at) i_nmi = 1'b1;
            if (n == stall_at) begin
                i_rdy = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    tick();
                    check($sformatf("%s_s%0d_hold%0d", tag, n, k), expected(n, rs, bs, pv, vec));
                end
                i_rdy = 1'b1;
            end
            tick();
        end
        check($sformatf("%s_end", tag), expected(0, 0, 0, 8'h00, 16'h0000));
    endtask

    initial begin
        rst = 1'b1; i_rdy = 1'b1; i_fetch = 1'b0; i_brk = 1'b0;
        i_nmi = 1'b0; i_irq = 1'b0; i_psr = 8'h00;

        // Reset state and power-on RST sequence.
        tick(); tick();
        check("reset", expected(0, 0, 0, 8'h00, 16'h0000));
        rst = 1'b0;
        tick();
        run_seq("rst", 1, 0, 8'h20, 16'hFFFC, 0, 0);
        tick();
        check("rst_no_repeat", expected(0, 0, 0, 8'h00, 16'h0000));

        // IRQ with I clear; IRQ dropped after start.
        i_psr = 8'h20; i_irq = 1'b1; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0; i_irq = 1'b0;
        run_seq("irq", 0, 0, 8'h20, 16'hFFFE, 0, 0);

        // IRQ masked by I; NMI edge taken at next fetch.
        i_psr = 8'h24; i_irq = 1'b1; i_fetch = 1'b1;
        tick();
        check("irq_masked", expected(0, 0, 0, 8'h00, 16'h0000));
        i_nmi = 1'b1; i_fetch = 1'b0;
        tick();
        check("nmi_wait_fetch", expected(0, 0, 0, 8'h00, 16'h0000));
        i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        run_seq("nmi", 0, 0, 8'h24, 16'hFFFA, 0, 0);
        i_fetch = 1'b1;
        tick();
        check("nmi_cleared", expected(0, 0, 0, 8'h00, 16'h0000));
        i_fetch = 1'b0; i_nmi = 1'b0; i_irq = 1'b0;
        tick();

        // BRK hijacked by NMI edge in S2.
        i_brk = 1'b1; i_fetch = 1'b1; i_psr = 8'h24;
        tick();
        i_brk = 1'b0; i_fetch = 1'b0;
        run_seq("brk_hijack", 0, 1, 8'h34, 16'hFFFA, 2, 0);
        i_fetch = 1'b1;
        tick();
        check("hijack_cleared", expected(0, 0, 0, 8'h00, 16'h0000));
        i_fetch = 1'b0; i_nmi = 1'b0;
        tick();

        // NMI edge after S5 stays pending for the next boundary.
        i_psr = 8'h20; i_irq = 1'b1; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        run_seq("irq_late_nmi", 0, 0, 8'h20, 16'hFFFE, 6, 0);
        i_irq = 1'b0; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0;
        run_seq("late_nmi", 0, 0, 8'h20, 16'hFFFA, 0, 0);
        i_nmi = 1'b0;
        tick();

        // IRQ with a 3-cycle stall in S4.
        i_psr = 8'h20; i_irq = 1'b1; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0; i_irq = 1'b0;
        run_seq("irq_stall", 0, 0, 8'h20, 16'hFFFE, 0, 4);

        // Reset in S4 of an IRQ sequence.
        i_psr = 8'h20; i_irq = 1'b1; i_fetch = 1'b1;
        tick();
        i_fetch = 1'b0; i_irq = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            check($sformatf("irq_abort_s%0d", n), expected(n, 0, 0, 8'h20, 16'hFFFE));
            tick();
        end
        check("irq_abort_s4", expected(4, 0, 0, 8'h20, 16'hFFFE));
        rst = 1'b1;
        tick();
        check("abort_reset", expected(0, 0, 0, 8'h00, 16'h0000));
        rst = 1'b0; i_psr = 8'h00;
        tick();
        run_seq("rst2", 1, 0, 8'h20, 16'hFFFC, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
